// File: rtl/logic_gate_tester_if.sv
// Bundle of stimulus, response and result signals between the gate tester and
// the gate under test / controlling logic.
interface logic_gate_tester_if;
  logic       start;
  logic [2:0] gate_sel;
  logic       a;
  logic       b;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  // Controller / gate-under-test side: requests runs and returns y.
  modport master (
    output start,
    output gate_sel,
    output y,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  fail_vec,
    input  err_count
  );

  // Tester side.
  modport slave (
    input  start,
    input  gate_sel,
    input  y,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output fail_vec,
    output err_count
  );
endinterface

// File: rtl/logic_gate_tester.sv
// Exhaustive two-input gate tester. Walks {a,b} through 00,01,10,11, holds each
// vector for SETTLE_CYCLES clocks, compares y against the selected gate function
// and reports per-vector mismatches, a mismatch count and an overall pass flag.
module logic_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  logic_gate_tester_if.slave  tst_io
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrive = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Settle counter value on the last cycle of a vector; y is sampled at its end.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] gate_q, gate_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_q, fail_d;
  logic [2:0] err_q, err_d;

  logic       mismatch;
  logic [2:0] err_upd;
  logic [1:0] idx_inc;

  // Reference truth table for the latched gate selection.
  function automatic logic gate_eval(input logic [2:0] sel, input logic in_a, input logic in_b);
    logic res;
    res = 1'b0;
    unique case (sel)
      3'd0: res = in_a & in_b;
      3'd1: res = in_a | in_b;
      3'd2: res = ~(in_a & in_b);
      3'd3: res = ~(in_a | in_b);
      3'd4: res = in_a ^ in_b;
      3'd5: res = ~(in_a ^ in_b);
      3'd6: res = ~in_a;
      3'd7: res = in_a;
    endcase
    return res;
  endfunction

  // Compare the currently driven vector against the expected gate output.
  always_comb begin
    mismatch = (tst_io.y != gate_eval(gate_q, a_q, b_q));
    err_upd  = (mismatch && (err_q != 3'd4)) ? err_q + 3'd1 : err_q;
    idx_inc  = idx_q + 2'd1;
  end

  // Next-state logic for the run sequencer and result registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;

    case (state_q)
      StIdle: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (tst_io.start) begin
          // gate_sel is captured once so mid-run changes cannot disturb the run.
          gate_d  = tst_io.gate_sel;
          fail_d  = 4'b0000;
          err_d   = 3'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = StDrive;
        end
      end

      StDrive: begin
        if (cnt_q == SettleLast) begin
          cnt_d         = 4'd0;
          fail_d[idx_q] = fail_q[idx_q] | mismatch;
          err_d         = err_upd;
          if (idx_q == 2'd3) begin
            // Final sample folds into pass in the same edge as it is taken.
            state_d = StDone;
            idx_d   = 2'd0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd == 3'd0);
          end else begin
            idx_d = idx_inc;
            a_d   = idx_inc[1];
            b_d   = idx_inc[0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      StDone: begin
        // start is deliberately not looked at here.
        state_d = StIdle;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
        cnt_d   = 4'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset that aborts any run without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      gate_q  <= 3'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'b0000;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign tst_io.a         = a_q;
  assign tst_io.b         = b_q;
  assign tst_io.busy      = busy_q;
  assign tst_io.done      = done_q;
  assign tst_io.pass      = pass_q;
  assign tst_io.fail_vec  = fail_q;
  assign tst_io.err_count = err_q;

endmodule

// File: doc/logic_gate_tester.md
LOGIC_GATE_TESTER -- requirements
Module: logic_gate_tester

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, giving the clock cycles each input vector is driven before y is sampled (legal range 1..15).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a test run; honoured only in IDLE.
REQ-005 SHALL have port gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT(a), 7 BUF(a).
REQ-006 SHALL have port a  output  1  stimulus to the DUT's first input.
REQ-007 SHALL have port b  output  1  stimulus to the DUT's second input.
REQ-008 SHALL have port y  input  1  DUT output; synchronous to clk, no synchroniser.
REQ-009 SHALL have port busy  output  1  high while a run is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at the end of a run.
REQ-011 SHALL have port pass  output  1  high when the last completed run had zero mismatches.
REQ-012 SHALL have port fail_vec  output  4  bit i set if vector i mismatched in the last run.
REQ-013 SHALL have port err_count  output  3  mismatch count of the last run, 0..4.

Function
REQ-014 SHALL implement states IDLE, DRIVE, DONE, all outputs registered.
REQ-015 IDLE: on start=1, latch gate_sel, clear fail_vec/err_count/pass, load vector index 0, enter DRIVE; busy=1 from the next cycle.
REQ-016 Vector order: index 0..3 drives {a,b} = 00, 01, 10, 11 (a = index[1], b = index[0]).
REQ-017 DRIVE: each vector held for exactly SETTLE_CYCLES cycles; y sampled at the edge ending the last of those cycles.
REQ-018 On sample, expected = latched gate function of {a,b}; if y != expected, set fail_vec[index] and increment err_count (saturates at 4).
REQ-019 After sampling index 3, enter DONE; otherwise advance index and restart the settle count.
REQ-020 Total busy duration SHALL be 4*SETTLE_CYCLES cycles; start sampled at edge N gives busy high in cycles N+1..N+4*SETTLE_CYCLES.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle, pass = (err_count==0 including final sample), then IDLE.
REQ-022 pass, fail_vec, err_count SHALL hold their values in IDLE until the next accepted start.
REQ-023 start while busy or in DONE SHALL be ignored; gate_sel changes during a run SHALL NOT affect it.
REQ-024 In IDLE and DONE, a and b SHALL be 0.

Reset
REQ-025 rst=1 SHALL, at the next edge, force IDLE; a=b=busy=done=pass=0, fail_vec=0, err_count=0, index and settle counter 0.
REQ-026 rst SHALL take priority over start and abort any run mid-operation with no done pulse.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-028 Good AND model, gate_sel=0, SETTLE_CYCLES=2, start at edge 0 -> busy cycles 1..8, {a,b} 00,00,01,01,10,10,11,11, done at cycle 9, pass=1, fail_vec=0000, err_count=0.
REQ-029 y tied to 0, gate_sel=0 -> pass=0, fail_vec=1000, err_count=1; gate_sel=2 (NAND) same tie -> fail_vec=0111, err_count=3.
REQ-030 y tied to 1, gate_sel=6 (NOT a) -> fail_vec=1100, err_count=2, pass=0; results held unchanged for 20 idle cycles.
REQ-031 Good XOR model, gate_sel=4, start re-pulsed at cycle 4 and gate_sel switched to 0 mid-run -> run unaffected, one done only, pass=1.
REQ-032 rst pulsed at cycle 5 of a run -> next cycle all outputs 0, no done; a new start then completes a normal run.
REQ-033 SETTLE_CYCLES=1, all 8 gate_sel values against a matching model -> each run busy exactly 4 cycles, pass=1 every time.
